// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, computes the result at issue and
// holds it in a buffer until a fixed busy period expires.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] rhi_reg, rhi_next;
    logic [31:0] rlo_reg, rlo_next;
    logic        dz_reg, dz_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    // One shared 64-bit multiplier: operands are sign- or zero-extended so the
    // low 64 bits of the product are correct for both mult and multu.
    logic [63:0] mul_a, mul_b, prod;
    logic        is_signed_div;
    logic [31:0] abs_a, abs_b;
    logic [31:0] dividend, divisor, divisor_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;

    always_comb begin
        mul_a = (op == OP_MULTU) ? {32'd0, src_a} : {{32{src_a[31]}}, src_a};
        mul_b = (op == OP_MULTU) ? {32'd0, src_b} : {{32{src_b[31]}}, src_b};
        prod  = mul_a * mul_b;
    end

    // Signed divide runs on magnitudes; signs are restored afterwards, which
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
    always_comb begin
        is_signed_div = (op == OP_DIV);
        abs_a         = src_a[31] ? (~src_a + 32'd1) : src_a;
        abs_b         = src_b[31] ? (~src_b + 32'd1) : src_b;
        dividend      = is_signed_div ? abs_a : src_a;
        divisor       = is_signed_div ? abs_b : src_b;
        divisor_safe  = (divisor == 32'd0) ? 32'd1 : divisor;
        q_mag         = dividend / divisor_safe;
        r_mag         = dividend % divisor_safe;
        quot          = q_mag;
        rem           = r_mag;
        if (is_signed_div) begin
            if (src_a[31] ^ src_b[31]) begin
                quot = ~q_mag + 32'd1;
            end
            if (src_a[31]) begin
                rem = ~r_mag + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rhi_reg   <= 32'd0;
            rlo_reg   <= 32'd0;
            dz_reg    <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rhi_reg   <= rhi_next;
            rlo_reg   <= rlo_next;
            dz_reg    <= dz_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rhi_next   = rhi_reg;
        rlo_next   = rlo_reg;
        dz_next    = dz_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            rhi_next   = prod[63:32];
                            rlo_next   = prod[31:0];
                            dz_next    = 1'b0;
                            cnt_next   = MULT_CNT;
                            state_next = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            rhi_next   = rem;
                            rlo_next   = quot;
                            dz_next    = (src_b == 32'd0);
                            cnt_next   = DIV_CNT;
                            state_next = RUN;
                        end
                        OP_MTHI: hi_next = src_a;
                        OP_MTLO: lo_next = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = IDLE;
                    // Divide by zero burns the full latency but leaves HI/LO alone.
                    if (!dz_reg) begin
                        hi_next = rhi_reg;
                        lo_next = rlo_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == RUN);
    assign stall_req = md_use & (busy | (start & ~op[2]));
    assign hi        = hi_reg;
    assign lo        = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pushed at issue, popped and
// compared when busy drops; busy length, stall_req and reset also checked.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        md_use = 1'b0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] sb_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .md_use(md_use),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1; op = o; src_a = a; src_b = 32'd0;
        step();
        start = 1'b0;
    endtask

    // Issues a long op, optionally injects a stray start in busy cycle inject_cyc,
    // then counts busy cycles and compares HI/LO against the scoreboard head.
    task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp_hilo,
                            input int exp_cyc, input int inject_cyc);
        int cyc;
        logic [63:0] exp;
        sb_q.push_back(exp_hilo);
        md_use = 1'b1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        check({tag, " stall_at_start"}, 64'(stall_req), 64'd1);
        step();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            if (cyc == 1) check({tag, " stall_busy"}, 64'(stall_req), 64'd1);
            if (cyc == inject_cyc) begin
                start = 1'b1; op = 3'd0; src_a = 32'd2; src_b = 32'd3;
            end
            step();
            start = 1'b0;
        end
        check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
        exp = sb_q.pop_front();
        check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
        check({tag, " stall_idle"}, 64'(stall_req), 64'd0);
        md_use = 1'b0;
    endtask

    initial begin
        // Reset state, with stall_req still driven by md_use & start_long.
        step();
        md_use = 1'b1; start = 1'b1; op = 3'd0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst stall_long", 64'(stall_req), 64'd1);
        op = 3'd4;
        #1;
        check("rst stall_mthi", 64'(stall_req), 64'd0);
        start = 1'b0; md_use = 1'b0;
        step();
        check("rst start_ignored", 64'(busy), 64'd0);
        reset = 1'b1;
        step();

        run_long("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5, 0);
        run_long("divu", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 0);
        run_long("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, 0);
        run_long("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10, 0);

        move_to(3'd4, 32'h11);
        check("mthi hi", 64'(hi), 64'h11);
        check("mthi busy", 64'(busy), 64'd0);
        move_to(3'd5, 32'h22);
        check("mtlo lo", 64'(lo), 64'h22);
        check("mtlo hi_kept", 64'(hi), 64'h11);
        move_to(3'd6, 32'h33);
        check("rsvd busy", 64'(busy), 64'd0);
        check("rsvd hilo", {32'(hi), 32'(lo)}, {32'h11, 32'h22});

        run_long("divu_zero", 3'd3, 32'd5, 32'd0, {32'h11, 32'h22}, 10, 0);
        run_long("multu_inj", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, 3);
        run_long("b2b_mult", 3'd0, 32'd2, 32'd3, {32'd0, 32'd6}, 5, 0);

        // Asynchronous reset in the middle of a run: no commit afterwards.
        start = 1'b1; op = 3'd0; src_a = 32'd2; src_b = 32'd3;
        step();
        start = 1'b0;
        step();
        check("midrst pre_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("midrst no_commit", {32'(hi), 32'(lo)}, 64'd0);
        check("midrst idle", 64'(busy), 64'd0);

        // Combinational stall_req in the start cycle.
        md_use = 1'b1; start = 1'b1; op = 3'd2; src_a = 32'd9; src_b = 32'd3;
        #1;
        check("stall div_start", 64'(stall_req), 64'd1);
        op = 3'd4;
        #1;
        check("stall mthi_start", 64'(stall_req), 64'd0);
        start = 1'b0;
        #1;
        check("stall idle", 64'(stall_req), 64'd0);
        md_use = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
